// File: rtl/dmem_ctrl.sv
// dmem_ctrl: multi-cycle data-memory access controller with pipeline stall and watchdog
module dmem_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       req;

    assign req     = mem_read_i | mem_write_i;
    assign stall_o = (state == IDLE) ? req : (state == BUSY);

    // Access FSM: latch in IDLE, wait for ack or watchdog in BUSY, release pipeline for one cycle in DONE
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            cnt           <= '0;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        mem_addr_o  <= addr_i;
                        mem_wdata_o <= wdata_i;
                        mem_we_o    <= mem_write_i;
                        err_o       <= err_o | (mem_read_i & mem_write_i);
                        cnt         <= '0;
                        mem_req_o   <= 1'b1;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= (cnt == 8'hff) ? cnt : cnt + 8'd1;
                    if (mem_ack_i || cnt == LAST) begin
                        if (!mem_we_o) rdata_o <= mem_ack_i ? mem_rdata_i : '0;
                        err_o         <= err_o | ~mem_ack_i;
                        mem_req_o     <= 1'b0;
                        rdata_valid_o <= ~mem_we_o;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    rdata_valid_o <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed and randomized checks of dmem_ctrl against a transaction-level model
module tb_dmem_ctrl;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        mem_read_i = 1'b0, mem_write_i = 1'b0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic        stall_o, rdata_valid_o, err_o, mem_req_o, mem_we_o;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic        m_we = 1'b0, m_err = 1'b0;

    dmem_ctrl #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // compare every output against the model at the current sample point
    task automatic chk_all(input logic stall, input logic req, input logic valid);
        chk("stall", stall_o, stall);
        chk("req", mem_req_o, req);
        chk("valid", rdata_valid_o, valid);
        chk("err", err_o, m_err);
        chk("rdata", rdata_o, m_rdata);
        chk("we", mem_we_o, m_we);
        chk("addr", mem_addr_o, m_addr);
        chk("wdata", mem_wdata_o, m_wdata);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // n cycles with no request; stray acks must be ignored
    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            mem_read_i  = 1'b0;
            mem_write_i = 1'b0;
            mem_ack_i   = $urandom_range(0, 1) == 1;
            mem_rdata_i = $urandom;
            @(negedge clk);
            chk_all(1'b0, 1'b0, 1'b0);
            next_cycle();
        end
    endtask

    // one access: request held from cycle 0 through DONE; ack_at=0 means never acked
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input int ack_at, input logic [31:0] rdat);
        int done = (ack_at > 0) ? ack_at + 1 : TO + 1;
        for (int c = 0; c <= done; c++) begin
            mem_read_i  = rd;
            mem_write_i = wr;
            addr_i      = a;
            wdata_i     = wd;
            mem_ack_i   = (ack_at > 0 && c == ack_at) ||
                          ((c == 0 || c == done) && $urandom_range(0, 1) == 1);
            mem_rdata_i = (c == ack_at) ? rdat : $urandom;
            if (c == 1) begin
                m_addr  = a;
                m_wdata = wd;
                m_we    = wr;
                if (rd && wr) m_err = 1'b1;
            end
            if (c == done) begin
                if (ack_at == 0) m_err = 1'b1;
                if (!wr) m_rdata = (ack_at > 0) ? rdat : 32'd0;
            end
            @(negedge clk);
            chk_all(c < done, c >= 1 && c < done, c == done && !wr);
            next_cycle();
        end
    endtask

    task automatic model_reset();
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_we = 1'b0; m_err = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk_all(1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;
        next_cycle();
        idle(2);
        access(1'b1, 1'b0, 32'h10, 32'h0, 3, 32'd155);
        access(1'b0, 1'b1, 32'h20, 32'hDEAD, 1, 32'h0);
        idle(1);
        access(1'b1, 1'b0, 32'h30, 32'h1, 1, 32'hAAAA_0001);
        access(1'b1, 1'b0, 32'h34, 32'h2, 1, 32'hBBBB_0002);
        access(1'b1, 1'b0, 32'h40, 32'h3, TO, 32'h1234_5678);
        chk("no_err_before_timeout", err_o, 1'b0);
        access(1'b1, 1'b0, 32'h50, 32'h4, 0, 32'h0);
        idle(10);
        chk("err_sticky", err_o, 1'b1);
        // reset during BUSY cycle 2 abandons the request
        mem_read_i = 1'b1; addr_i = 32'h60; mem_ack_i = 1'b0;
        @(negedge clk);
        chk("rst_c0_stall", stall_o, 1'b1);
        next_cycle();
        @(negedge clk);
        chk("rst_c1_req", mem_req_o, 1'b1);
        next_cycle();
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst_c2_req", mem_req_o, 1'b1);
        next_cycle();
        rst_i = 1'b0; mem_read_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        model_reset();
        @(negedge clk);
        chk_all(1'b0, 1'b0, 1'b0);
        next_cycle();
        idle(2);
        access(1'b1, 1'b1, 32'h70, 32'hCAFE, 2, 32'h0);
        idle(1);
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
        model_reset();
        idle(1);
        for (int i = 0; i < 60; i++) begin
            int k = $urandom_range(0, 9);
            logic rd = (k < 5) || (k == 9);
            logic wr = (k >= 5);
            access(rd, wr, $urandom, $urandom, $urandom_range(0, TO), $urandom);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
